// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes and FSM state encoding shared by the alu_seq slice
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_MUL  = 4'h2;
  localparam logic [3:0] ALU_DIV  = 4'h3;
  localparam logic [3:0] ALU_SHL  = 4'h4;
  localparam logic [3:0] ALU_SHR  = 4'h5;
  localparam logic [3:0] ALU_ROL  = 4'h6;
  localparam logic [3:0] ALU_ROR  = 4'h7;
  localparam logic [3:0] ALU_AND  = 4'h8;
  localparam logic [3:0] ALU_OR   = 4'h9;
  localparam logic [3:0] ALU_XOR  = 4'hA;
  localparam logic [3:0] ALU_NOR  = 4'hB;
  localparam logic [3:0] ALU_NAND = 4'hC;
  localparam logic [3:0] ALU_XNOR = 4'hD;
  localparam logic [3:0] ALU_GT   = 4'hE;
  localparam logic [3:0] ALU_EQ   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per clock
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   res
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 busy_q, busy_d;
  logic                 div_q, div_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial;
  logic                 ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   step;

  // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    trial   = acc_q[2*WIDTH-1:WIDTH-1];
    ge      = (trial >= {1'b0, opnd_q});
    rem_new = ge ? (trial[WIDTH-1:0] - opnd_q) : trial[WIDTH-1:0];
    step    = div_q ? {rem_new, acc_q[WIDTH-2:0], ge} : {mul_sum, acc_q[WIDTH-1:1]};
  end

  assign done = busy_q && (cnt_q == LAST);
  assign res  = step;

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = is_div;
      cnt_d  = '0;
      acc_d  = {{WIDTH{1'b0}}, (is_div ? a : b)};
      opnd_d = is_div ? b : a;
    end else if (busy_q) begin
      acc_d = step;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU top: handshakes, FSM, single-cycle decode, result/flag registers
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 div_by_zero
);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;

  logic                 accept;
  logic                 md_start;
  logic                 md_done;
  logic [2*WIDTH-1:0]   md_res;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [2*WIDTH-1:0]   sc_res;
  logic                 sc_carry;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};

  // DIV only reaches this decode when b == 0: saturated quotient, remainder = a
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op)
      ALU_ADD:  begin sc_res = {{(WIDTH-1){1'b0}}, add_sum}; sc_carry = add_sum[WIDTH]; end
      ALU_SUB:  begin sc_res = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]}; sc_carry = sub_diff[WIDTH]; end
      ALU_MUL:  sc_res = '0;
      ALU_DIV:  sc_res = {a, {WIDTH{1'b1}}};
      ALU_SHL:  sc_res = {{WIDTH{1'b0}}, a[WIDTH-2:0], 1'b0};
      ALU_SHR:  sc_res = {{WIDTH{1'b0}}, 1'b0, a[WIDTH-1:1]};
      ALU_ROL:  sc_res = {{WIDTH{1'b0}}, a[WIDTH-2:0], a[WIDTH-1]};
      ALU_ROR:  sc_res = {{WIDTH{1'b0}}, a[0], a[WIDTH-1:1]};
      ALU_AND:  sc_res = {{WIDTH{1'b0}}, a & b};
      ALU_OR:   sc_res = {{WIDTH{1'b0}}, a | b};
      ALU_XOR:  sc_res = {{WIDTH{1'b0}}, a ^ b};
      ALU_NOR:  sc_res = {{WIDTH{1'b0}}, ~(a | b)};
      ALU_NAND: sc_res = {{WIDTH{1'b0}}, ~(a & b)};
      ALU_XNOR: sc_res = {{WIDTH{1'b0}}, ~(a ^ b)};
      ALU_GT:   sc_res = {{(2*WIDTH-1){1'b0}}, (a > b)};
      ALU_EQ:   sc_res = {{(2*WIDTH-1){1'b0}}, (a == b)};
      default:  sc_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    md_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == ALU_MUL) begin
            md_start = 1'b1;
            state_d  = S_MUL;
          end else if ((op == ALU_DIV) && (b != '0)) begin
            md_start = 1'b1;
            state_d  = S_DIV;
          end else begin
            result_d = sc_res;
            carry_d  = sc_carry;
            zero_d   = (sc_res == '0);
            dbz_d    = (op == ALU_DIV);
            state_d  = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (md_done) begin
          result_d = md_res;
          carry_d  = 1'b0;
          zero_d   = (md_res == '0);
          dbz_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (op == ALU_DIV),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .res    (md_res)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [3:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           carry;
  logic           zero;
  logic           div_by_zero;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry       (carry),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input int ma, input int mb, input int mop,
                       output int r, output int c, output int dz, output int lat);
    c   = 0;
    dz  = 0;
    lat = 1;
    case (mop)
      0:  begin r = ma + mb; c = (r > 255) ? 1 : 0; end
      1:  begin r = (ma - mb + 256) % 256; c = (ma < mb) ? 1 : 0; end
      2:  begin r = ma * mb; lat = 9; end
      3:  begin
            if (mb == 0) begin r = ma * 256 + 255; dz = 1; end
            else begin r = (ma % mb) * 256 + (ma / mb); lat = 9; end
          end
      4:  r = (ma * 2) % 256;
      5:  r = ma / 2;
      6:  r = (ma * 2) % 256 + ma / 128;
      7:  r = ma / 2 + (ma % 2) * 128;
      8:  r = ma & mb;
      9:  r = ma | mb;
      10: r = ma ^ mb;
      11: r = 255 - (ma | mb);
      12: r = 255 - (ma & mb);
      13: r = 255 - (ma ^ mb);
      14: r = (ma > mb) ? 1 : 0;
      default: r = (ma == mb) ? 1 : 0;
    endcase
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_b, input logic [3:0] top, input int hold);
    int r, c, dz, lat_exp, lat;
    model(int'(ta), int'(tb_b), int'(top), r, c, dz, lat_exp);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_b; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(posedge clk); #1; end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("in_ready_done", 32'(in_ready), 32'd0);
      chk("result", 32'(result), 32'(r));
      chk("carry", 32'(carry), 32'(c));
      chk("zero", 32'(zero), (r == 0) ? 32'd1 : 32'd0);
      chk("div_by_zero", 32'(div_by_zero), 32'(dz));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [3:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {29'd0, carry, zero, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'hFF, 8'h01, 4'h0, 0);
    run_op(8'h03, 8'h05, 4'h1, 0);
    run_op(8'hFF, 8'hFF, 4'h2, 0);
    run_op(8'd200, 8'd7, 4'h3, 0);
    run_op(8'h55, 8'h00, 4'h3, 0);
    run_op(8'h81, 8'h00, 4'h6, 0);
    run_op(8'h81, 8'h00, 4'h7, 0);
    run_op(8'hF0, 8'hFF, 4'hC, 0);
    run_op(8'h3C, 8'h3C, 4'hF, 0);
    run_op(8'h5A, 8'h5A, 4'hA, 0);
    run_op(8'h00, 8'h00, 4'h2, 0);
    run_op(8'h12, 8'h34, 4'h0, 10);

    // async reset in the middle of a multiply discards it
    run_op(8'h40, 8'h41, 4'h0, 0);
    a = 8'hAB; b = 8'hCD; op = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h21, 8'h42, 4'h0, 0);
    run_op(8'h0F, 8'h03, 4'h2, 2);

    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      rop = 4'($urandom_range(0, 15));
      run_op(ra, rb, rop, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
